alu_seg7_display: RTL and testbench

- Downstream consumer of the 4-bit ALU result on the Basys3 board.
- Time-multiplexes the four 7-segment digits to show, left to right: result Y, opcode, B, A. This is the same nibble order as the LED map, `led[15:12]`..`led[3:0]`.
- Inputs are snapshotted once per frame, so a frame never tears.
- Between digit slots there is a blanking gap that suppresses ghosting.

---
 rtl/alu_display_pkg.sv | 45 ++++
 rtl/alu_seg7_display_hex_to_seg7.sv | 35 +++
 rtl/alu_seg7_display.sv | 151 +++++++++++++++
 tb/tb_alu_seg7_display.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_display_pkg.sv
// Shared types and constants for the ALU result 7-segment display.
//   seg7_t     : 7-bit cathode vector {g,f,e,d,c,b,a}, active-low
//   state_t    : scan FSM states (BLANK, DISPLAY)
//   snap_t     : per-frame snapshot of all displayed inputs
//   DIG_*      : digit slot indices, rightmost (A) to leftmost (Y)
//   SEG_OFF    : all segments dark
package alu_display_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic {
        BLANK   = 1'b0,
        DISPLAY = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] result;
        logic [3:0] alu_op;
        logic [3:0] input_b;
        logic [3:0] input_a;
        logic [3:0] en;
        logic [3:0] dp;
    } snap_t;

    localparam logic [1:0] DIG_A  = 2'd0;
    localparam logic [1:0] DIG_B  = 2'd1;
    localparam logic [1:0] DIG_OP = 2'd2;
    localparam logic [1:0] DIG_Y  = 2'd3;

    localparam seg7_t SEG_OFF = 7'b1111111;

    // Pick the snapshot nibble shown in digit slot idx.
    function automatic logic [3:0] sel_nibble(input snap_t s, input logic [1:0] idx);
        logic [3:0] n;
        case (idx)
            DIG_A:   n = s.input_a;
            DIG_B:   n = s.input_b;
            DIG_OP:  n = s.alu_op;
            DIG_Y:   n = s.result;
            default: n = s.input_a;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alu_seg7_display_hex_to_seg7.sv
// Combinational hex nibble to 7-segment decoder (active-low cathodes).
//   nibble : 4-bit value 0..F
//   seg    : cathodes {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg7
    import alu_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    // Hex glyph lookup; lowercase b and d keep them distinct from 8 and 0.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/alu_seg7_display.sv
// Time-multiplexed 4-digit 7-segment display of the ALU state.
// Left to right: result Y, opcode, B, A. Inputs are snapshotted once per
// frame (entering digit 0) so a frame never mixes old and new values, and
// every digit slot is preceded by an all-dark gap to suppress ghosting.
//   clk, rst   : clock and asynchronous active-high reset
//   input_a/b  : operands (digits 0 and 1)
//   alu_op     : opcode (digit 2)
//   result     : ALU result (digit 3)
//   digit_en   : per-digit anode enable, slot timing unaffected
//   dp_in      : per-digit decimal point, active-high
//   seg, dp, an: active-low cathodes/anodes, all registered
//   frame_tick : one-cycle pulse on the cycle the snapshot is taken
module alu_seg7_display
    import alu_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] input_a,
    input  logic [3:0] input_b,
    input  logic [3:0] alu_op,
    input  logic [3:0] result,
    input  logic [3:0] digit_en,
    input  logic [3:0] dp_in,
    output seg7_t      seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    if (DIGIT_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_param_check
        $error("alu_seg7_display: DIGIT_CYCLES and BLANK_CYCLES must both be >= 1");
    end

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    idx_r, idx_s;
    snap_t         snap_r, snap_s;
    logic          tick_s;

    logic [3:0]    nib_s;
    seg7_t         dec_s;
    seg7_t         seg_s;
    logic          dp_s;
    logic [3:0]    an_s;

    // Scan sequencing: counter, digit index and once-per-frame snapshot.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        snap_s  = snap_r;
        tick_s  = 1'b0;
        case (state_r)
            BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = DISPLAY;
                    cnt_s   = CNT_ZERO;
                    // Capture only when entering digit 0 so the frame is coherent.
                    if (idx_r == DIG_A) begin
                        snap_s = '{result:  result,
                                   alu_op:  alu_op,
                                   input_b: input_b,
                                   input_a: input_a,
                                   en:      digit_en,
                                   dp:      dp_in};
                        tick_s = 1'b1;
                    end else begin
                        snap_s = snap_r;
                        tick_s = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DISPLAY: begin
                if (cnt_r == DIGIT_LAST) begin
                    state_s = BLANK;
                    cnt_s   = CNT_ZERO;
                    idx_s   = idx_r + 2'd1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = BLANK;
                cnt_s   = CNT_ZERO;
                idx_s   = DIG_A;
            end
        endcase
    end

    // Outputs are computed from next-state values so they are registered
    // yet line up with the slot being entered (including a fresh snapshot).
    assign nib_s = sel_nibble(snap_s, idx_s);

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nib_s),
        .seg    (dec_s)
    );

    // Anode/cathode drive for the slot being entered.
    always_comb begin
        an_s  = 4'b1111;
        seg_s = SEG_OFF;
        dp_s  = 1'b1;
        if (state_s == DISPLAY) begin
            an_s[idx_s] = ~snap_s.en[idx_s];
            seg_s       = dec_s;
            dp_s        = ~snap_s.dp[idx_s];
        end else begin
            an_s  = 4'b1111;
            seg_s = SEG_OFF;
            dp_s  = 1'b1;
        end
    end

    // State, snapshot and output registers; reset blanks the display at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= BLANK;
            cnt_r      <= CNT_ZERO;
            idx_r      <= DIG_A;
            snap_r     <= snap_t'(24'h000000);
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            snap_r     <= snap_s;
            an         <= an_s;
            seg        <= seg_s;
            dp         <= dp_s;
            frame_tick <= tick_s;
        end
    end

endmodule

// File: tb/tb_alu_seg7_display.sv
// Self-checking bench for alu_seg7_display with DIGIT_CYCLES=4, BLANK_CYCLES=2.
// Expected outputs come from a timeline model: after reset release, edge k
// (k>=2) sits at offset u=k-2 in a 6-cycle slot pattern (4 lit, 2 dark) over
// a 24-cycle frame; inputs are latched by the model at each frame start.
module tb_alu_seg7_display;

    localparam int DC     = 4;
    localparam int BC     = 2;
    localparam int SLOT   = DC + BC;
    localparam int FRAME  = 4 * SLOT;

    localparam logic [6:0] TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] input_a = 4'h0;
    logic [3:0] input_b = 4'h0;
    logic [3:0] alu_op = 4'h0;
    logic [3:0] result = 4'h0;
    logic [3:0] digit_en = 4'h0;
    logic [3:0] dp_in = 4'h0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int compared   = 0;
    int mismatched = 0;

    // Model state
    int         k = 0;
    logic [3:0] m_nib [4];
    logic [3:0] m_en = 4'h0;
    logic [3:0] m_dp = 4'h0;
    logic       cur_disp = 1'b0;
    int         cur_slot = 0;

    alu_seg7_display #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .input_a    (input_a),
        .input_b    (input_b),
        .alu_op     (alu_op),
        .result     (result),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        cmp({tag, "_an"},   7'(an),         7'h0F);
        cmp({tag, "_seg"},  seg,            7'h7F);
        cmp({tag, "_dp"},   7'(dp),         7'h01);
        cmp({tag, "_tick"}, 7'(frame_tick), 7'h00);
    endtask

    // Advance one edge, update the model, and compare every output.
    task automatic step();
        int         kn;
        int         u;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_tick;
        kn = k + 1;
        if (kn >= 2 && ((kn - 2) % FRAME) == 0) begin
            m_nib[0] = input_a;
            m_nib[1] = input_b;
            m_nib[2] = alu_op;
            m_nib[3] = result;
            m_en     = digit_en;
            m_dp     = dp_in;
        end
        @(posedge clk);
        #1;
        k = kn;
        u = k - 2;
        cur_disp = (k >= 2) && ((u % SLOT) < DC);
        cur_slot = (k >= 2) ? ((u / SLOT) % 4) : 0;
        e_tick   = (k >= 2) && ((u % FRAME) == 0);
        e_an     = 4'b1111;
        e_seg    = 7'b1111111;
        e_dp     = 1'b1;
        if (cur_disp) begin
            if (m_en[cur_slot]) e_an = ~(4'b0001 << cur_slot);
            e_seg = TBL[m_nib[cur_slot]];
            e_dp  = ~m_dp[cur_slot];
        end
        cmp("an",   7'(an),         7'(e_an));
        cmp("seg",  seg,            e_seg);
        cmp("dp",   7'(dp),         7'(e_dp));
        cmp("tick", 7'(frame_tick), 7'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Bounded advance until the given slot is lit.
    task automatic step_to_slot(input int s);
        for (int i = 0; i < 2 * FRAME && !(cur_disp && cur_slot == s); i++) step();
    endtask

    initial begin
        // 1. Reset held 5 cycles, then release; first lit slot 2 edges later.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_reset_outputs("rst_hold");
        end
        input_a  = 4'h3;
        input_b  = 4'h5;
        alu_op   = 4'hA;
        result   = 4'hF;
        digit_en = 4'b1111;
        dp_in    = 4'b0000;
        rst      = 1'b0;
        k        = 0;

        // 2. Basic pattern, two full frames.
        run(2 * FRAME + 2);

        // 3. Change Y during slot 1; current frame keeps F, next shows 0.
        step_to_slot(1);
        result = 4'h0;
        run(2 * FRAME);

        // 4. Disabled digits and decimal point on a dark digit.
        digit_en = 4'b0101;
        dp_in    = 4'b1000;
        run(2 * FRAME);
        digit_en = 4'b1111;
        dp_in    = 4'b0110;
        run(FRAME);

        // 5. Asynchronous reset in the middle of slot 2.
        step_to_slot(2);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_reset_outputs("rst_mid");
        end
        rst = 1'b0;
        k   = 0;
        cur_disp = 1'b0;
        run(FRAME + 2);

        // 6. Sweep all input_a values through the decoder.
        for (int v = 0; v < 16; v++) begin
            input_a = 4'(v);
            dp_in   = 4'($urandom_range(0, 15));
            run(FRAME);
        end

        // Randomized inputs changing at arbitrary cycles.
        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                input_a  = 4'($urandom);
                input_b  = 4'($urandom);
                alu_op   = 4'($urandom);
                result   = 4'($urandom);
                digit_en = 4'($urandom);
                dp_in    = 4'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
